// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage: FSM states,
// IF/ID bundle, and default reset PC / halt sentinel.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hDEADBEEF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

endpackage : fetch_pkg

// File: rtl/fetch_req_tracker.sv
// Tracks the single read in flight to the instruction memory and selects the
// address presented to it (redirect, replay on stall, or the next sequential PC).
module fetch_req_tracker
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        halt_hit_i,
  output logic [31:0] req_pc_o,
  output logic        req_valid_o,
  output logic [31:0] pc_address_o
);

  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default infers a latch.
  always_comb begin
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (run_i) begin
      if (branch_taken_i) begin
        req_pc_d    = branch_target_i;
        req_valid_d = 1'b1;
      end else if (!stall_i) begin
        if (halt_hit_i) begin
          req_valid_d = 1'b0;
        end else begin
          req_pc_d    = fetch_pc_i;
          req_valid_d = 1'b1;
        end
      end
    end
  end

  // On stall the memory must re-present the word already in flight.
  always_comb begin
    pc_address_o = fetch_pc_i;
    if (run_i && branch_taken_i) begin
      pc_address_o = branch_target_i;
    end else if (run_i && stall_i && req_valid_q) begin
      pc_address_o = req_pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign req_pc_o    = req_pc_q;
  assign req_valid_o = req_valid_q;

endmodule : fetch_req_tracker

// File: rtl/instruction_fetch_stage.sv
// Fetch sequencer: owns the PC and the IF/ID register, handles stall, branch
// redirect with squash, and freezes on the halt sentinel until reset.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instruction,
  output logic [31:0] pc_address,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  ifid_t        ifid_q, ifid_d;

  logic [31:0]  req_pc;
  logic         req_valid;
  logic         run;
  logic         halt_hit;

  assign run      = (state_q == ST_RUN);
  assign halt_hit = req_valid && (imem_instruction == HALT_WORD);

  fetch_req_tracker u_req_tracker (
    .clk             (clk),
    .reset           (reset),
    .run_i           (run),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .fetch_pc_i      (fetch_pc_q),
    .halt_hit_i      (halt_hit),
    .req_pc_o        (req_pc),
    .req_valid_o     (req_valid),
    .pc_address_o    (pc_address)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ifid_d     = ifid_q;
    if (run) begin
      if (branch_taken) begin
        // Squash both the captured word and the one returning this cycle.
        ifid_d.valid = 1'b0;
        fetch_pc_d   = branch_target + 32'd1;
      end else if (!stall) begin
        if (halt_hit) begin
          ifid_d.valid = 1'b0;
          state_d      = ST_HALT;
        end else begin
          if (req_valid) begin
            ifid_d.instruction = imem_instruction;
            ifid_d.pc          = req_pc;
            ifid_d.valid       = 1'b1;
          end else begin
            ifid_d.valid = 1'b0;
          end
          fetch_pc_d = fetch_pc_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      ifid_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ifid_q     <= ifid_d;
    end
  end

  assign ifid_instruction = ifid_q.instruction;
  assign ifid_pc          = ifid_q.pc;
  assign ifid_valid       = ifid_q.valid;
  assign halted           = (state_q == ST_HALT);

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed vector tables,
// halt/wrap/async-reset sequences, and randomized run against a queue model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] HALT = 32'hDEADBEEF;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_q;
  logic [31:0] pc_address, ifid_instruction, ifid_pc;
  logic        ifid_valid, halted;

  logic        rst2;
  logic [31:0] imem2_q;
  logic [31:0] pc_address2, ifid_instruction2, ifid_pc2;
  logic        ifid_valid2, halted2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_instruction (imem_q),
    .pc_address       (pc_address),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .halted           (halted)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
    .clk              (clk),
    .reset            (rst2),
    .stall            (1'b0),
    .branch_taken     (1'b0),
    .branch_target    (32'h0),
    .imem_instruction (imem2_q),
    .pc_address       (pc_address2),
    .ifid_instruction (ifid_instruction2),
    .ifid_pc          (ifid_pc2),
    .ifid_valid       (ifid_valid2),
    .halted           (halted2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd8) ? HALT : BASE + a;
  endfunction

  // One-cycle registered-read memories; the second never returns the sentinel.
  always @(posedge clk) begin
    imem_q  <= mem_word(pc_address);
    imem2_q <= BASE + pc_address2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1;
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_addr", pc_address, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[20];

  task automatic run_vectors(input int first, input int n, input string tag);
    for (int i = first; i < first + n; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      #1;
      check($sformatf("%s[%0d].pc_address", tag, i), pc_address, vecs[i].exp_addr);
      edge_step();
      check($sformatf("%s[%0d].valid", tag, i), {31'b0, ifid_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("%s[%0d].halted", tag, i), {31'b0, halted}, 32'd0);
      if (vecs[i].exp_valid) begin
        check($sformatf("%s[%0d].ifid_pc", tag, i), ifid_pc, vecs[i].exp_pc);
        check($sformatf("%s[%0d].instr", tag, i), ifid_instruction, BASE + vecs[i].exp_pc);
      end
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  // Reference model: a queue of outstanding reads and the architectural view of IF/ID.
  logic [31:0] m_fetch, m_ifid_pc, m_ifid_instr;
  logic        m_ifid_valid, m_halted;
  logic [31:0] m_inflight[$];

  function automatic void model_reset();
    m_fetch = 32'd0; m_ifid_valid = 1'b0; m_halted = 1'b0;
    m_ifid_pc = '0; m_ifid_instr = '0;
    m_inflight.delete();
  endfunction

  function automatic logic [31:0] model_addr(input logic s, input logic b, input logic [31:0] t);
    if (!m_halted && b) return t;
    if (!m_halted && s && m_inflight.size() > 0) return m_inflight[0];
    return m_fetch;
  endfunction

  function automatic void model_step(input logic s, input logic b, input logic [31:0] t);
    if (m_halted) return;
    if (b) begin
      m_ifid_valid = 1'b0;
      m_inflight.delete();
      m_inflight.push_back(t);
      m_fetch = t + 32'd1;
    end else if (!s) begin
      if (m_inflight.size() > 0 && mem_word(m_inflight[0]) == HALT) begin
        m_ifid_valid = 1'b0;
        m_inflight.delete();
        m_halted = 1'b1;
      end else begin
        if (m_inflight.size() > 0) begin
          m_ifid_pc    = m_inflight.pop_front();
          m_ifid_instr = mem_word(m_ifid_pc);
          m_ifid_valid = 1'b1;
        end else begin
          m_ifid_valid = 1'b0;
        end
        m_inflight.push_back(m_fetch);
        m_fetch = m_fetch + 32'd1;
      end
    end
  endfunction

  initial begin
    // T1 + T2: sequential fetch then a three-cycle stall at ifid_pc=3.
    vecs[0]  = '{0, 0, 0, 32'd0, 0, 32'd0};
    vecs[1]  = '{0, 0, 0, 32'd1, 1, 32'd0};
    vecs[2]  = '{0, 0, 0, 32'd2, 1, 32'd1};
    vecs[3]  = '{0, 0, 0, 32'd3, 1, 32'd2};
    vecs[4]  = '{0, 0, 0, 32'd4, 1, 32'd3};
    vecs[5]  = '{1, 0, 0, 32'd4, 1, 32'd3};
    vecs[6]  = '{1, 0, 0, 32'd4, 1, 32'd3};
    vecs[7]  = '{1, 0, 0, 32'd4, 1, 32'd3};
    vecs[8]  = '{0, 0, 0, 32'd5, 1, 32'd4};
    vecs[9]  = '{0, 0, 0, 32'd6, 1, 32'd5};
    // T3 + T4: branch at ifid_pc=2, then branch together with stall.
    vecs[10] = '{0, 0, 0,      32'd0,  0, 32'd0};
    vecs[11] = '{0, 0, 0,      32'd1,  1, 32'd0};
    vecs[12] = '{0, 0, 0,      32'd2,  1, 32'd1};
    vecs[13] = '{0, 0, 0,      32'd3,  1, 32'd2};
    vecs[14] = '{0, 1, 32'h20, 32'h20, 0, 32'd0};
    vecs[15] = '{0, 0, 0,      32'h21, 1, 32'h20};
    vecs[16] = '{0, 0, 0,      32'h22, 1, 32'h21};
    vecs[17] = '{1, 1, 32'h30, 32'h30, 0, 32'd0};
    vecs[18] = '{0, 0, 0,      32'h31, 1, 32'h30};
    vecs[19] = '{0, 0, 0,      32'h32, 1, 32'h31};

    reset = 1'b0; rst2 = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    do_reset();
    run_vectors(0, 10, "seq_stall");
    do_reset();
    run_vectors(10, 10, "branch");

    // T5: run into the sentinel at address 8, then confirm the freeze.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      edge_step();
      if (k >= 2 && k <= 9) check($sformatf("halt_run.pc%0d", k), ifid_pc, 32'(k - 2));
      if (k == 9) check("halt_run.valid9", {31'b0, ifid_valid}, 32'd1);
    end
    check("halt.valid", {31'b0, ifid_valid}, 32'd0);
    check("halt.halted", {31'b0, halted}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      stall = ($urandom_range(0, 1) == 1);
      branch_taken = ($urandom_range(0, 1) == 1);
      branch_target = 32'h40 + 32'(k);
      #1;
      check("halt.pc_address", pc_address, 32'd9);
      edge_step();
      check("halt.frozen_halted", {31'b0, halted}, 32'd1);
      check("halt.frozen_valid", {31'b0, ifid_valid}, 32'd0);
    end
    do_reset();
    edge_step();
    edge_step();
    check("restart.valid", {31'b0, ifid_valid}, 32'd1);
    check("restart.pc", ifid_pc, 32'd0);
    check("restart.halted", {31'b0, halted}, 32'd0);

    // T6: 32-bit wrap from RESET_PC=FFFFFFFE, then async reset between edges.
    @(negedge clk);
    rst2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      if (k >= 2) begin
        check($sformatf("wrap.valid%0d", k), {31'b0, ifid_valid2}, 32'd1);
        check($sformatf("wrap.pc%0d", k), ifid_pc2, 32'hFFFF_FFFE + 32'(k - 2));
        check($sformatf("wrap.instr%0d", k), ifid_instruction2, BASE + 32'hFFFF_FFFE + 32'(k - 2));
      end
    end
    #2 rst2 = 1'b0;
    #1;
    check("async_rst.valid", {31'b0, ifid_valid2}, 32'd0);
    check("async_rst.pc", ifid_pc2, 32'd0);
    check("async_rst.instr", ifid_instruction2, 32'd0);
    check("async_rst.halted", {31'b0, halted2}, 32'd0);
    check("async_rst.addr", pc_address2, 32'hFFFF_FFFE);

    // Randomized run against the queue model, resetting a few cycles after each halt.
    do_reset();
    model_reset();
    begin
      int halt_cycles = 0;
      logic [31:0] exp_addr;
      for (int c = 0; c < 400; c++) begin
        if (m_halted && halt_cycles >= 3) begin
          do_reset();
          model_reset();
          halt_cycles = 0;
        end
        stall = ($urandom_range(0, 3) == 0);
        branch_taken = ($urandom_range(0, 7) == 0);
        branch_target = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7))
                                                    : 32'($urandom_range(9, 60));
        exp_addr = model_addr(stall, branch_taken, branch_target);
        #1;
        check("rand.pc_address", pc_address, exp_addr);
        @(posedge clk);
        model_step(stall, branch_taken, branch_target);
        @(negedge clk);
        if (m_halted) halt_cycles++;
        check("rand.valid", {31'b0, ifid_valid}, {31'b0, m_ifid_valid});
        check("rand.halted", {31'b0, halted}, {31'b0, m_halted});
        if (m_ifid_valid) begin
          check("rand.ifid_pc", ifid_pc, m_ifid_pc);
          check("rand.instr", ifid_instruction, m_ifid_instr);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instruction_fetch_stage
